// File: rtl/sample_sched_pkg.sv
// Shared types and arbitration helpers for the sample source scheduler.
// Used by sample_source_sched; fixed priority build selected with SAMPLE_SCHED_FIXED_PRIO_EN.
package sample_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARB   = 2'd1,
      BURST = 2'd2
   } state_t;

   function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
      logic [4:0] idx;
      idx = '0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) idx = 5'(i);
      end
      return idx;
   endfunction

   // One-hot winner of a circular search over n requesters starting at ptr.
   function automatic logic [31:0] rr_search(input logic [31:0] reqs,
                                             input int unsigned ptr,
                                             input int unsigned n);
      logic [31:0] g;
      int unsigned idx;
      g = '0;
      for (int unsigned k = 0; k < 32; k++) begin
         idx = ptr + k;
         if (idx >= n) idx = idx - n;
         if (k < n && g == '0 && reqs[idx[4:0]]) g[idx[4:0]] = 1'b1;
      end
      return g;
   endfunction

endpackage

// File: rtl/sample_sched_skid.sv
// Two-entry FIFO holding source rows with their owner id, valid/ready on both sides.
// Output data reads as zero while empty.
module sample_sched_skid #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   fill
);
   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   count;
   logic         push;
   logic         pop;

   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign fill      = count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   // Storage carries no reset; emptiness is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

endmodule

// File: rtl/sample_source_sched.sv
// Shares one row-per-cycle sample source among NUM_REQ consumers in whole bursts.
// Define SAMPLE_SCHED_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round robin.
module sample_source_sched
   import sample_sched_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 8,
   parameter int LEN_W      = 8,
   localparam int ID_W      = $clog2(NUM_REQ),
   localparam int ROW_W     = LANES * DATA_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*LEN_W-1:0] req_len,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [NUM_REQ-1:0]       done,
   output logic                     src_en,
   input  logic [ROW_W-1:0]         src_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ROW_W-1:0]         out_data,
   output logic [ID_W-1:0]          out_id
);
   state_t            state;
   state_t            state_nxt;
   logic [31:0]       win_oh;
   logic [ID_W-1:0]   win_idx;
   logic [LEN_W-1:0]  win_len;
   logic [ID_W-1:0]   owner;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W:0]    issued;
   logic [LEN_W:0]    accepted;
   logic              vld_p1;
   logic              accept;
   logic              burst_end;
   logic              skid_in_rdy;
   logic [1:0]        skid_fill;
   logic [2:0]        outstanding;

`ifdef SAMPLE_SCHED_FIXED_PRIO_EN
   assign win_oh = rr_search(32'(req), 0, NUM_REQ);
`else
   logic [ID_W-1:0] rr_ptr;

   assign win_oh = rr_search(32'(req), 32'(rr_ptr), NUM_REQ);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (state == ARB && |req) begin
         rr_ptr <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
      end
   end
`endif

   assign win_idx = ID_W'(onehot_to_idx(win_oh));
   assign win_len = req_len[win_idx*LEN_W +: LEN_W];

   assign accept    = out_valid && out_ready;
   assign burst_end = (len_q == '0) || (accept && (accepted + 1'b1 == {1'b0, len_q}));
   // Rows in flight plus buffered, after this cycle's accept, must leave room for one more.
   assign outstanding = 3'(vld_p1) + 3'(skid_fill) - 3'(accept);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|req) state_nxt = ARB;
         ARB:     state_nxt = (|req) ? BURST : IDLE;
         BURST:   if (burst_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      gnt    = '0;
      done   = '0;
      src_en = 1'b0;
      if (state == BURST) begin
         gnt[owner] = 1'b1;
         src_en     = (issued < {1'b0, len_q}) && (outstanding < 3'd2);
         if (burst_end) done[owner] = 1'b1;
      end
   end

   // p0 -> p1: src_en issues a row; the source presents it one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner    <= '0;
         len_q    <= '0;
         issued   <= '0;
         accepted <= '0;
         vld_p1   <= 1'b0;
      end else begin
         vld_p1 <= src_en;
         if (state == ARB) begin
            owner    <= win_idx;
            len_q    <= win_len;
            issued   <= '0;
            accepted <= '0;
         end else begin
            if (src_en) issued   <= issued + 1'b1;
            if (accept) accepted <= accepted + 1'b1;
         end
      end
   end

   // p1 -> buffer: the row arriving from the source is captured with its owner tag.
   sample_sched_skid #(
      .W (ROW_W + ID_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (vld_p1),
      .in_ready  (skid_in_rdy),
      .in_data   ({owner, src_data}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  ({out_id, out_data}),
      .fill      (skid_fill)
   );

endmodule
